// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared display geometry and streamer state encoding
package oled_pkg;
  localparam int H_PIXELS = 128;
  localparam int V_PIXELS = 64;
  localparam int PAGES    = V_PIXELS / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_READ = ST_READ,
    S_HOLD = ST_HOLD,
    S_DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/oled_page_streamer.sv
// rtl/oled_page_streamer.sv - streams the framebuffer as SSD1306 page-order column bytes
module oled_page_streamer #(
  parameter int H_PIXELS = oled_pkg::H_PIXELS,
  parameter int V_PIXELS = oled_pkg::V_PIXELS,
  parameter int LSB_TOP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  input  logic       fb_busy,
  output logic       fb_re,
  output logic       fb_r_mode,
  output logic [7:0] fb_r_xpos,
  output logic [7:0] fb_r_ypos,
  input  logic       fb_r_valid,
  input  logic [7:0] fb_dout,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_first,
  output logic       m_page_start
);
  import oled_pkg::*;

  localparam int PAGES_L = V_PIXELS / 8;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_col;
  logic [4:0] r_page;
  logic [7:0] r_data;
  logic       r_rd_first;
  logic [7:0] w_rev;
  logic       w_last;
  logic       w_cap;
  logic       w_hs;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    if (LSB_TOP != 0) begin : g_rev
      assign w_rev[i] = fb_dout[7-i];
    end else begin : g_pass
      assign w_rev[i] = fb_dout[i];
    end
  end

  assign w_last = (r_page == 5'(PAGES_L - 1)) && (r_col == 8'(H_PIXELS - 1));
  // A stale r_data_valid may linger into the first READ cycle; never trust it.
  assign w_cap  = (r_state == S_READ) && !r_rd_first && fb_r_valid;
  assign w_hs   = (r_state == S_HOLD) && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_page     <= '0;
      r_data     <= '0;
      r_rd_first <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_first <= (w_next == S_READ) && (r_state != S_READ);
      if (r_state == S_IDLE && w_next == S_READ) begin
        r_col  <= '0;
        r_page <= '0;
      end
      if (w_cap) r_data <= w_rev;
      if (w_hs && !w_last) begin
        if (r_col == 8'(H_PIXELS - 1)) begin
          r_col  <= '0;
          r_page <= r_page + 5'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start && !fb_busy) w_next = S_READ;
      S_READ: if (w_cap) w_next = S_HOLD;
      S_HOLD: if (m_ready) w_next = w_last ? S_DONE : S_READ;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy         = (r_state == S_READ) || (r_state == S_HOLD);
  assign fb_re        = (r_state == S_READ);
  assign m_valid      = (r_state == S_HOLD);
  assign frame_done   = (r_state == S_DONE);
  assign fb_r_mode    = 1'b1;
  assign fb_r_xpos    = r_col;
  assign fb_r_ypos    = {r_page, 3'b000};
  assign m_data       = r_data;
  assign m_first      = m_valid && (r_col == 8'd0) && (r_page == 5'd0);
  assign m_page_start = m_valid && (r_col == 8'd0);
endmodule

// File: tb/tb_oled_page_streamer.sv
// tb/tb_oled_page_streamer.sv - directed bench with a behavioural column-read framebuffer
module tb_oled_page_streamer;
  localparam int LAT = 3;
  localparam int NB  = 1024;

  logic       clk = 1'b0;
  logic       rst, start, fb_busy, fb_re, fb_r_mode, fb_r_valid;
  logic       busy, frame_done, m_valid, m_ready, m_first, m_page_start;
  logic [7:0] fb_r_xpos, fb_r_ypos, fb_dout, m_data;
  logic       force_busy;

  oled_page_streamer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .fb_busy(fb_busy), .fb_re(fb_re), .fb_r_mode(fb_r_mode),
    .fb_r_xpos(fb_r_xpos), .fb_r_ypos(fb_r_ypos), .fb_r_valid(fb_r_valid),
    .fb_dout(fb_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_first(m_first), .m_page_start(m_page_start)
  );

  always #5 clk = ~clk;

  // Framebuffer model: valid/data are registered, so valid lingers one cycle after re drops.
  logic fb_mem [0:63][0:127];
  int   fb_cnt = 0;
  assign fb_busy = fb_re | force_busy;

  function automatic logic [7:0] col_byte(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = fb_mem[(int'(y) + i) % 64][int'(x) % 128];
    return b;
  endfunction

  initial begin
    fb_r_valid = 1'b0;
    fb_dout    = 8'h00;
  end

  always @(posedge clk) begin
    fb_cnt     <= fb_re ? fb_cnt + 1 : 0;
    fb_r_valid <= (fb_cnt >= LAT);
    if (fb_re && fb_cnt == LAT) fb_dout <= col_byte(fb_r_xpos, fb_r_ypos);
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] cap  [0:NB-1];
  logic [7:0] saved[0:NB-1];
  int nbytes, done_pulses, stall_err, ps_err, first_err, last_hs, done_at, post_re;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected byte: bit i is row page*8+i of column col.
  function automatic logic [7:0] exp_byte(input int idx);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = fb_mem[(idx / 128) * 8 + i][idx % 128];
    return b;
  endfunction

  function automatic int count_mism();
    int m = 0;
    for (int k = 0; k < NB; k++) if (cap[k] !== exp_byte(k)) m++;
    return m;
  endfunction

  task automatic clear_fb();
    for (int y = 0; y < 64; y++) for (int x = 0; x < 128; x++) fb_mem[y][x] = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input int dup_at, input int rst_at);
    logic [9:0] held;
    bit stalled = 0, dup_done = 0;
    nbytes = 0; done_pulses = 0; stall_err = 0; ps_err = 0; first_err = 0;
    last_hs = -10; done_at = -1; post_re = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      m_ready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
      start   = (dup_at >= 0) && (nbytes == dup_at) && !dup_done;
      if (start) dup_done = 1;
      if (stalled && (!m_valid || {m_first, m_page_start, m_data} !== held)) stall_err++;
      if (frame_done) begin
        done_pulses++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && fb_re) post_re++;
      if (m_valid && m_ready) begin
        if (nbytes < NB) cap[nbytes] = m_data;
        if (m_page_start !== (nbytes % 128 == 0)) ps_err++;
        if (m_first !== (nbytes == 0)) first_err++;
        nbytes++;
        last_hs = cyc;
      end
      stalled = m_valid && !m_ready;
      held    = {m_first, m_page_start, m_data};
      if (rst_at >= 0 && nbytes == rst_at && fb_re) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_fb_re", fb_re, 1'b0);
        check("rst_mid_m_valid", m_valid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        rst = 1'b0;
        return;
      end
      if (done_at >= 0 && cyc >= done_at + 20) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; force_busy = 1'b0;
    clear_fb();
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_fb_re", fb_re, 1'b0);
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_m_first", m_first, 1'b0);
    check("reset_r_mode", fb_r_mode, 1'b1);
    check("reset_m_data", m_data, 8'h00);
    rst = 1'b0;

    // FF written at row 0, x=0..7: each of columns 0..7 carries only its top row
    for (int x = 0; x < 8; x++) fb_mem[0][x] = 1'b1;
    run_frame(0, -1, -1);
    check("A_byte0", cap[0], 8'h01);
    check("A_byte7", cap[7], 8'h01);
    check("A_byte8", cap[8], 8'h00);
    check("A_first_err", first_err, 0);
    check("A_nbytes", nbytes, NB);
    check("A_mism", count_mism(), 0);

    clear_fb();
    run_frame(0, -1, -1);
    check("B_nbytes", nbytes, NB);
    check("B_mism", count_mism(), 0);
    check("B_page_start_err", ps_err, 0);
    check("B_first_err", first_err, 0);
    check("B_done_pulses", done_pulses, 1);
    check("B_done_after_last", done_at, last_hs + 1);
    check("B_busy_after", busy, 1'b0);

    fb_mem[13][5] = 1'b1;
    fb_mem[63][127] = 1'b1;
    run_frame(0, -1, -1);
    check("C_byte133", cap[133], 8'h20);
    check("C_byte1023", cap[1023], 8'h80);
    check("C_byte132", cap[132], 8'h00);
    check("C_mism", count_mism(), 0);
    for (int k = 0; k < NB; k++) saved[k] = cap[k];

    run_frame(1, -1, -1);
    begin
      int diff = 0;
      for (int k = 0; k < NB; k++) if (cap[k] !== saved[k]) diff++;
      check("D_seq_vs_ready1", diff, 0);
    end
    check("D_nbytes", nbytes, NB);
    check("D_stall_stable", stall_err, 0);
    check("D_page_start_err", ps_err, 0);

    force_busy = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      int re_seen = 0, busy_seen = 0;
      repeat (30) begin
        if (fb_re) re_seen++;
        if (busy) busy_seen++;
        @(negedge clk);
      end
      check("E_fb_busy_no_re", re_seen, 0);
      check("E_fb_busy_no_busy", busy_seen, 0);
    end
    force_busy = 1'b0;

    run_frame(0, 500, -1);
    check("F_dup_nbytes", nbytes, NB);
    check("F_dup_done_pulses", done_pulses, 1);
    check("F_dup_no_restart", post_re, 0);

    run_frame(0, -1, 300);
    run_frame(0, -1, -1);
    check("G_nbytes", nbytes, NB);
    check("G_mism", count_mism(), 0);
    check("G_first_err", first_err, 0);
    check("G_done_pulses", done_pulses, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
